fifo_arbiter: RTL and testbench

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arbiter_if.sv | 41 ++++
 rtl/fifo_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_arbiter_if.sv
// Handshake bundle between two requesters, the external FIFO and the consumer of fifo_arbiter.
// slave is the arbiter's view; master is the environment (requesters, FIFO, consumer).
interface fifo_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  req0_valid;
    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req0_data;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req0_ready;
    logic                  req1_ready;

    logic                  fifo_w_en;
    logic [DATA_WIDTH-1:0] fifo_w_data;
    logic                  fifo_r_en;
    logic [DATA_WIDTH-1:0] fifo_r_data;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    logic [ADDR_WIDTH:0]   level;
    logic                  last_grant;

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
        input  fifo_r_data, out_ready,
        output req0_ready, req1_ready,
        output fifo_w_en, fifo_w_data, fifo_r_en,
        output out_valid, out_data, level, last_grant
    );

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
        output fifo_r_data, out_ready,
        input  req0_ready, req1_ready,
        input  fifo_w_en, fifo_w_data, fifo_r_en,
        input  out_valid, out_data, level, last_grant
    );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin 2:1 writer into an external FIFO with a registered read side; write->out_valid >= 3 cycles.
// Requesters stall (ready low) while level==FIFO_DEPTH; consumer stall holds out_data and stops reads.
module fifo_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fifo_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } rd_state_e;

    localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH+1)'(1);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  last_grant_q, last_grant_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic accept;
    logic gnt0;
    logic gnt1;
    logic w_en;
    logic r_en;

    // Own occupancy count: a read issued this cycle never frees space for this cycle's write.
    always_comb begin
        accept       = !rst && (level_q < DEPTH);
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        if (accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
        w_en         = gnt0 | gnt1;
        last_grant_d = w_en ? gnt1 : last_grant_q;
    end

    always_comb begin
        state_d     = state_q;
        r_en        = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    r_en    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                out_data_d  = bus.fifo_r_data;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (level_q != '0) begin
                        r_en    = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            r_en = 1'b0;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({w_en, r_en})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            level_q      <= '0;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.fifo_w_en   = w_en;
    assign bus.fifo_w_data = gnt1 ? bus.req1_data : bus.req0_data;
    assign bus.fifo_r_en   = r_en;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.level       = level_q;
    assign bus.last_grant  = last_grant_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a behavioural 16-entry FIFO and an in-order scoreboard.
module tb_fifo_arbiter;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_arbiter #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural FIFO: read data registered, valid the cycle after fifo_r_en.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    always @(posedge clk) begin
        if (rst) begin
            wp              <= '0;
            rp              <= '0;
            bus.fifo_r_data <= '0;
        end else begin
            if (bus.fifo_w_en) begin
                mem[wp] <= bus.fifo_w_data;
                wp      <= wp + 1'b1;
            end
            if (bus.fifo_r_en) begin
                bus.fifo_r_data <= mem[rp];
                rp              <= rp + 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: words accepted from the requester inputs must appear at out_data in order.
    logic [DW-1:0] sb [$];
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("order", 32'(bus.out_data), 32'(sb.pop_front()));
                end
            end
            if (bus.req0_ready) sb.push_back(bus.req0_data);
            if (bus.req1_ready) sb.push_back(bus.req1_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h11;
        bus.req1_data  = 8'h22;
        bus.out_ready  = 1'b0;

        // Reset: outputs gated while rst is high, registers at reset values afterwards
        tick();
        tick();
        settle();
        chk("rst_r0_rdy", 32'(bus.req0_ready), 32'd0);
        chk("rst_r1_rdy", 32'(bus.req1_ready), 32'd0);
        chk("rst_w_en",   32'(bus.fifo_w_en),  32'd0);
        chk("rst_r_en",   32'(bus.fifo_r_en),  32'd0);
        tick();
        rst            = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        settle();
        chk("rst_level",      32'(bus.level),      32'd0);
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_out_data",   32'(bus.out_data),   32'd0);
        chk("rst_last_grant", 32'(bus.last_grant), 32'd1);
        chk("rst_idle_r_en",  32'(bus.fifo_r_en),  32'd0);

        // Single write of 0xA5: out_valid three cycles after accept, then held
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hA5;
        settle();
        chk("a5_rdy",    32'(bus.req0_ready),  32'd1);
        chk("a5_w_en",   32'(bus.fifo_w_en),   32'd1);
        chk("a5_w_data", 32'(bus.fifo_w_data), 32'hA5);
        tick();
        bus.req0_valid = 1'b0;
        settle();
        chk("a5_c1_level", 32'(bus.level),      32'd1);
        chk("a5_c1_r_en",  32'(bus.fifo_r_en),  32'd1);
        chk("a5_c1_vld",   32'(bus.out_valid),  32'd0);
        chk("a5_c1_lg",    32'(bus.last_grant), 32'd0);
        tick();
        settle();
        chk("a5_c2_level", 32'(bus.level),     32'd0);
        chk("a5_c2_r_en",  32'(bus.fifo_r_en), 32'd0);
        chk("a5_c2_vld",   32'(bus.out_valid), 32'd0);
        tick();
        settle();
        chk("a5_c3_vld",  32'(bus.out_valid), 32'd1);
        chk("a5_c3_data", 32'(bus.out_data),  32'hA5);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk("a5_hold_vld",  32'(bus.out_valid), 32'd1);
            chk("a5_hold_data", 32'(bus.out_data),  32'hA5);
            chk("a5_hold_r_en", 32'(bus.fifo_r_en), 32'd0);
        end
        tick();
        bus.out_ready = 1'b1;
        settle();
        chk("a5_take_r_en", 32'(bus.fifo_r_en), 32'd0);
        tick();
        settle();
        chk("a5_after_vld", 32'(bus.out_valid), 32'd0);

        // Continuous contention: grants alternate 0,1,0,1 starting with requester 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            bus.req0_data  = 8'(8'h10 + i);
            bus.req1_data  = 8'(8'h80 + i);
            bus.out_ready  = 1'b1;
            settle();
            chk("rr_r0", 32'(bus.req0_ready), 32'((i % 2) == 0));
            chk("rr_r1", 32'(bus.req1_ready), 32'((i % 2) == 1));
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (40) tick();
        settle();
        chk("rr_drain_level", 32'(bus.level),     32'd0);
        chk("rr_drain_vld",   32'(bus.out_valid), 32'd0);
        chk("rr_drain_sb",    32'(sb.size()),     32'd0);

        // Fill: one word parked in HOLD, then 16 writes bring level to 16 and stall the 17th
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h20;
        tick();
        bus.req0_valid = 1'b0;
        repeat (4) tick();
        settle();
        chk("fill_pre_vld",   32'(bus.out_valid), 32'd1);
        chk("fill_pre_level", 32'(bus.level),     32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 8'(8'h21 + i);
            settle();
            chk("fill_rdy", 32'(bus.req0_ready), 32'd1);
            tick();
        end
        bus.req0_data = 8'h31;
        settle();
        chk("full_level", 32'(bus.level),      32'd16);
        chk("full_rdy",   32'(bus.req0_ready), 32'd0);
        chk("full_w_en",  32'(bus.fifo_w_en),  32'd0);

        // Full FIFO with draining consumer: writes only when level < 16
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.out_ready  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.req1_data = 8'(8'hC0 + k);
            settle();
            if (k == 0) begin
                chk("fd_k0_rdy",  32'(bus.req1_ready), 32'd0);
                chk("fd_k0_r_en", 32'(bus.fifo_r_en),  32'd1);
            end
            if (k == 1) begin
                chk("fd_k1_level", 32'(bus.level),      32'd15);
                chk("fd_k1_rdy",   32'(bus.req1_ready), 32'd1);
            end
            chk("fd_accept", 32'(bus.req1_ready), 32'(bus.level < 5'd16));
            chk("fd_max",    32'(bus.level <= 5'd16), 32'd1);
            tick();
        end
        bus.req1_valid = 1'b0;
        repeat (60) tick();
        settle();
        chk("fd_drain_level", 32'(bus.level),     32'd0);
        chk("fd_drain_vld",   32'(bus.out_valid), 32'd0);
        chk("fd_drain_sb",    32'(sb.size()),     32'd0);

        // Write and read in the same cycle at level 5
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h50;
        tick();
        bus.req0_valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = 8'(8'h51 + i);
            tick();
        end
        bus.req0_valid = 1'b0;
        settle();
        chk("wr_pre_level", 32'(bus.level), 32'd5);
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h56;
        bus.out_ready  = 1'b1;
        settle();
        chk("wr_w_en",  32'(bus.fifo_w_en), 32'd1);
        chk("wr_r_en",  32'(bus.fifo_r_en), 32'd1);
        chk("wr_level", 32'(bus.level),     32'd5);
        tick();
        bus.req0_valid = 1'b0;
        bus.out_ready  = 1'b0;
        settle();
        chk("wr_post_level", 32'(bus.level), 32'd5);
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h57;
        tick();
        bus.req0_data  = 8'h58;
        tick();
        bus.req0_valid = 1'b0;
        settle();
        chk("hold7_level", 32'(bus.level),     32'd7);
        chk("hold7_vld",   32'(bus.out_valid), 32'd1);
        chk("hold7_data",  32'(bus.out_data),  32'h51);

        // Reset pulse while in HOLD with level 7
        tick();
        rst            = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        settle();
        chk("mid_rst_rdy",  32'(bus.req0_ready), 32'd0);
        chk("mid_rst_w_en", 32'(bus.fifo_w_en),  32'd0);
        chk("mid_rst_r_en", 32'(bus.fifo_r_en),  32'd0);
        tick();
        rst            = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        settle();
        chk("post_rst_level", 32'(bus.level),      32'd0);
        chk("post_rst_vld",   32'(bus.out_valid),  32'd0);
        chk("post_rst_data",  32'(bus.out_data),   32'd0);
        chk("post_rst_lg",    32'(bus.last_grant), 32'd1);
        chk("post_rst_r_en",  32'(bus.fifo_r_en),  32'd0);
        tick();
        settle();
        chk("post_rst_idle_vld", 32'(bus.out_valid), 32'd0);
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h61;
        bus.req1_data  = 8'h62;
        settle();
        chk("post_rst_r0", 32'(bus.req0_ready), 32'd1);
        chk("post_rst_r1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (10) tick();
        settle();
        chk("end_sb",    32'(sb.size()), 32'd0);
        chk("end_level", 32'(bus.level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
